// File: rtl/pconv_seq.sv
// pconv_seq: time-multiplexed 1x1 convolution; all output lanes in parallel, one input channel per cycle.
// Accept to out_vld is IN_CH+2 cycles (best rate one pixel per IN_CH+3); the result is held while out_rdy is low.
module pconv_seq #(
    parameter int N          = 16,
    parameter int IN_CH      = 6,
    parameter int OUT_CH     = 32,
    parameter int INPUT_SIZE = 6,
    parameter int RELU       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [IN_CH*N-1:0]         in_din,
    input  logic [OUT_CH*IN_CH*N-1:0]  weight_din,
    input  logic [OUT_CH*32-1:0]       bias_din,
    input  logic [OUT_CH*5-1:0]        shift_din,
    output logic [OUT_CH*N-1:0]        out_dout,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic                       frame_end
);

    localparam int PIX = INPUT_SIZE * INPUT_SIZE;
    localparam int CW  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int PW  = (PIX > 1) ? $clog2(PIX) : 1;
    localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (N - 1)) - 32'sd1;
    localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (N - 1));

    typedef enum logic [1:0] {IDLE, MAC, POST, OUT} state_t;

    state_t             state;
    logic [IN_CH*N-1:0] pix;
    logic [CW-1:0]      ch;
    logic [PW-1:0]      pix_cnt;
    logic signed [31:0] acc [OUT_CH];
    logic signed [N-1:0] x_sel;
    logic signed [31:0] prod [OUT_CH];
    logic signed [31:0] sum [OUT_CH];
    logic signed [31:0] shr [OUT_CH];
    logic signed [31:0] sat [OUT_CH];
    logic [OUT_CH*N-1:0] res;

    assign in_rdy = ce && (state == IDLE);

    // One shared input channel feeds every lane's multiplier this cycle.
    always_comb begin
        x_sel = pix[int'(ch)*N +: N];
        for (int i = 0; i < OUT_CH; i++) begin
            prod[i] = 32'((2*N)'(x_sel) *
                          (2*N)'($signed(weight_din[(i*IN_CH + int'(ch))*N +: N])));
        end
    end

    always_comb begin
        res = '0;
        for (int i = 0; i < OUT_CH; i++) begin
            sum[i] = acc[i] + $signed(bias_din[i*32 +: 32]);
            shr[i] = sum[i] >>> shift_din[i*5 +: 5];
            if (shr[i] > SAT_MAX)
                sat[i] = SAT_MAX;
            else if (shr[i] < SAT_MIN)
                sat[i] = SAT_MIN;
            else
                sat[i] = shr[i];
            if ((RELU != 0) && (sat[i] < 0))
                sat[i] = '0;
            res[i*N +: N] = sat[i][N-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_vld   <= 1'b0;
            out_dout  <= '0;
            frame_end <= 1'b0;
            ch        <= '0;
            pix_cnt   <= '0;
            pix       <= '0;
            for (int i = 0; i < OUT_CH; i++) acc[i] <= '0;
        end else if (ce) begin
            frame_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_vld) begin
                        pix   <= in_din;
                        ch    <= '0;
                        state <= MAC;
                        for (int i = 0; i < OUT_CH; i++) acc[i] <= '0;
                    end
                end
                MAC: begin
                    for (int i = 0; i < OUT_CH; i++) acc[i] <= acc[i] + prod[i];
                    if (ch == CW'(IN_CH - 1)) begin
                        ch    <= '0;
                        state <= POST;
                    end else begin
                        ch <= ch + CW'(1);
                    end
                end
                POST: begin
                    out_dout <= res;
                    out_vld  <= 1'b1;
                    state    <= OUT;
                end
                OUT: begin
                    if (out_rdy) begin
                        out_vld <= 1'b0;
                        state   <= IDLE;
                        // Last pixel of the frame: pulse and wrap so frames can run back to back.
                        if (pix_cnt == PW'(PIX - 1)) begin
                            pix_cnt   <= '0;
                            frame_end <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + PW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pconv_seq.sv
// Scoreboard bench for pconv_seq: two instances (RELU=0 and RELU=1) share stimulus and are checked against a reference model.
module tb_pconv_seq;
    localparam int N  = 16;
    localparam int IC = 3;
    localparam int OC = 2;
    localparam int IS = 2;
    localparam int FR = IS * IS;

    logic clk = 1'b0;
    logic rst, ce, in_vld, out_rdy;
    logic [IC*N-1:0]    in_din;
    logic [OC*IC*N-1:0] weight_din;
    logic [OC*32-1:0]   bias_din;
    logic [OC*5-1:0]    shift_din;
    logic in_rdy0, in_rdy1, out_vld0, out_vld1, fe0, fe1;
    logic [OC*N-1:0] dout0, dout1;

    always #5 clk = ~clk;

    pconv_seq #(.N(N), .IN_CH(IC), .OUT_CH(OC), .INPUT_SIZE(IS), .RELU(0)) u0 (
        .clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld), .in_rdy(in_rdy0), .in_din(in_din),
        .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
        .out_dout(dout0), .out_vld(out_vld0), .out_rdy(out_rdy), .frame_end(fe0));

    pconv_seq #(.N(N), .IN_CH(IC), .OUT_CH(OC), .INPUT_SIZE(IS), .RELU(1)) u1 (
        .clk(clk), .rst(rst), .ce(ce), .in_vld(in_vld), .in_rdy(in_rdy1), .in_din(in_din),
        .weight_din(weight_din), .bias_din(bias_din), .shift_din(shift_din),
        .out_dout(dout1), .out_vld(out_vld1), .out_rdy(out_rdy), .frame_end(fe1));

    logic signed [N-1:0] pin [IC];
    logic signed [N-1:0] wt  [OC][IC];
    int bias [OC];
    int shv  [OC];

    typedef struct {
        logic [OC*N-1:0] e0;
        logic [OC*N-1:0] e1;
    } exp_t;
    exp_t sbq[$];

    int errors = 0;
    int checks = 0;
    int fe_pulses = 0;
    bit rnd_on = 1'b0;
    time last_acc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pack();
        for (int k = 0; k < IC; k++) in_din[k*N +: N] = pin[k];
        for (int i = 0; i < OC; i++) begin
            for (int k = 0; k < IC; k++) weight_din[(i*IC+k)*N +: N] = wt[i][k];
            bias_din[i*32 +: 32] = bias[i];
            shift_din[i*5 +: 5]  = 5'(shv[i]);
        end
    endtask

    // Reference: exact products, 32-bit wrapping sum, floor shift, clamp, optional ReLU.
    function automatic logic [N-1:0] lane_ref(input int lane, input bit relu);
        longint acc;
        logic [31:0] a32;
        int s;
        int r;
        acc = 0;
        for (int k = 0; k < IC; k++) acc += longint'(pin[k]) * longint'(wt[lane][k]);
        a32 = acc[31:0];
        s = $signed(a32 + 32'(bias[lane]));
        r = s >>> shv[lane];
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return r[N-1:0];
    endfunction

    function automatic logic [OC*N-1:0] ref_vec(input bit relu);
        logic [OC*N-1:0] v;
        for (int i = 0; i < OC; i++) v[i*N +: N] = lane_ref(i, relu);
        return v;
    endfunction

    task automatic send(input bit chk_gap);
        int cnt;
        exp_t e;
        pack();
        in_vld = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!in_rdy0 && cnt < 300);
        check("accept_timeout", 64'(cnt < 300), 64'(1));
        check("in_rdy_sync", 64'(in_rdy1), 64'(in_rdy0));
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        if (chk_gap) check("accept_gap", 64'($time - last_acc), 64'((IC + 3) * 10));
        last_acc = $time;
        e.e0 = ref_vec(1'b0);
        e.e1 = ref_vec(1'b1);
        sbq.push_back(e);
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (sbq.size() != 0 && cnt < 600) begin
            @(negedge clk);
            cnt++;
        end
        check("drain_timeout", 64'(cnt < 600), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_vld0 && n < 60);
    endtask

    function automatic logic signed [N-1:0] rnd_val();
        if ($urandom_range(0, 2) == 0) return N'($urandom);
        return N'($urandom_range(0, 40)) - 16'sd20;
    endfunction

    // Monitor: pops the scoreboard on each output transfer and tracks the frame boundary.
    bit fe_exp = 1'b0;
    int xfer = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fe0) fe_pulses++;
            if (fe_exp || fe0) check("frame_end0", 64'(fe0), 64'(fe_exp));
            if (fe_exp || fe1) check("frame_end1", 64'(fe1), 64'(fe_exp));
            if (rst) begin
                sbq.delete();
                xfer = 0;
                fe_exp = 1'b0;
            end else if (ce) begin
                fe_exp = 1'b0;
                if (out_vld0 && out_rdy) begin
                    check("vld_sync", 64'(out_vld1), 64'(1));
                    if (sbq.size() == 0) begin
                        check("unexpected_output", 64'(1), 64'(0));
                    end else begin
                        e = sbq.pop_front();
                        check("dout_relu0", 64'(dout0), 64'(e.e0));
                        check("dout_relu1", 64'(dout1), 64'(e.e1));
                    end
                    xfer++;
                    if (xfer == FR) begin
                        fe_exp = 1'b1;
                        xfer = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_on) begin
                out_rdy = ($urandom_range(0, 3) != 0);
                ce      = ($urandom_range(0, 7) != 0);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; ce = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
        for (int k = 0; k < IC; k++) pin[k] = '0;
        for (int i = 0; i < OC; i++) begin
            for (int k = 0; k < IC; k++) wt[i][k] = '0;
            bias[i] = 0;
            shv[i]  = 0;
        end
        pack();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_vld", 64'(out_vld0), 64'(0));
        check("rst_dout", 64'(dout0), 64'(0));
        check("rst_frame_end", 64'(fe0), 64'(0));
        check("rst_in_rdy", 64'(in_rdy0), 64'(1));
        @(posedge clk);
        #1;

        // Basic
        pin = '{16'sd1, 16'sd2, 16'sd3};
        wt[0] = '{16'sd4, 16'sd5, 16'sd6};
        wt[1] = '{-16'sd1, -16'sd1, -16'sd1};
        bias = '{10, 0};
        send(1'b0);
        wait_vld(n);
        check("latency", 64'(n), 64'(IC + 2));
        check("basic_lane0", 64'(dout0[N-1:0]), 64'(42));
        check("basic_lane1", 64'(dout0[2*N-1:N]), 64'(16'hFFFA));
        drain();

        // Saturation
        pin = '{16'sd32767, 16'sd32767, 16'sd32767};
        wt[0] = '{16'sd32767, 16'sd32767, 16'sd0};
        wt[1] = '{-16'sd32768, -16'sd32768, 16'sd0};
        bias = '{0, 0};
        send(1'b0);
        drain();

        // Shift and ReLU
        pin = '{16'sd100, 16'sd0, 16'sd0};
        wt[0] = '{16'sd3, 16'sd0, 16'sd0};
        wt[1] = '{16'sd0, 16'sd0, 16'sd0};
        bias = '{-4, -6};
        shv = '{2, 0};
        send(1'b0);
        wait_vld(n);
        check("shift_lane0", 64'(dout0[N-1:0]), 64'(74));
        check("relu_lane1", 64'(dout1[2*N-1:N]), 64'(0));
        drain();

        // Backpressure
        out_rdy = 1'b0;
        pin = '{16'sd7, -16'sd9, 16'sd11};
        shv = '{0, 1};
        send(1'b0);
        wait_vld(n);
        check("bp_vld_timeout", 64'(n < 60), 64'(1));
        repeat (5) begin
            @(negedge clk);
            check("bp_out_vld", 64'(out_vld0), 64'(1));
            check("bp_in_rdy", 64'(in_rdy0), 64'(0));
            if (sbq.size() > 0) check("bp_dout", 64'(dout0), 64'(sbq[0].e0));
            else check("bp_sb_empty", 64'(0), 64'(1));
        end
        @(posedge clk);
        #1;
        out_rdy = 1'b1;
        drain();
        @(negedge clk);
        check("bp_idle_in_rdy", 64'(in_rdy0), 64'(1));
        check("bp_idle_out_vld", 64'(out_vld0), 64'(0));
        @(posedge clk);
        #1;

        // Reset during MAC drops the pixel
        send(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mac_rst_out_vld", 64'(out_vld0), 64'(0));
        check("mac_rst_in_rdy", 64'(in_rdy0), 64'(1));
        repeat (12) @(negedge clk);
        check("mac_rst_no_output", 64'(out_vld0), 64'(0));
        @(posedge clk);
        #1;

        // Two back-to-back frames
        fe_pulses = 0;
        for (int p = 0; p < 2 * FR; p++) begin
            for (int k = 0; k < IC; k++) pin[k] = rnd_val();
            send(p != 0);
        end
        drain();
        repeat (3) @(negedge clk);
        check("frame_pulses", 64'(fe_pulses), 64'(2));
        @(posedge clk);
        #1;

        // ce stall mid-MAC
        send(1'b0);
        ce = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            n++;
            check("ce_in_rdy", 64'(in_rdy0), 64'(0));
        end
        @(posedge clk);
        #1;
        ce = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!out_vld0 && n < 60);
        check("ce_latency", 64'(n), 64'(IC + 5));
        drain();

        // Randomised frames
        rnd_on = 1'b1;
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < OC; i++) begin
                for (int k = 0; k < IC; k++) wt[i][k] = rnd_val();
                bias[i] = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
                shv[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
            end
            for (int p = 0; p < FR; p++) begin
                for (int k = 0; k < IC; k++) pin[k] = rnd_val();
                send(1'b0);
            end
            drain();
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2;
        ce = 1'b1;
        out_rdy = 1'b1;
        drain();
        repeat (5) @(negedge clk);
        check("final_sb_empty", 64'(sbq.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
